// File: rtl/or_4_bit_arbiter_pkg.sv
// Shared types and constants for the or_4_bit round-robin arbiter.
// Holds the FSM state encoding, the operand width and the settle-counter width.
package or_arb_pkg;

    localparam int OPW  = 4;
    localparam int CNTW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Expected gate output for a captured {d,c,b,a} operand.
    function automatic logic or_reduce(input logic [OPW-1:0] v);
        return |v;
    endfunction

endpackage

// File: rtl/or_4_bit_arbiter_if.sv
// Client-side request/result bundle of the or_4_bit arbiter.
// master = requester side, slave = arbiter side.
interface or_4_bit_arbiter_if
    import or_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]     req;
    logic [OPW*NREQ-1:0] op;
    logic [NREQ-1:0]     ack;
    logic                res_valid;
    logic [IDW-1:0]      res_id;
    logic                res;

    modport master (
        output req, op,
        input  ack, res_valid, res_id, res
    );

    modport slave (
        input  req, op,
        output ack, res_valid, res_id, res
    );
endinterface

// File: rtl/or_4_bit_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from
// last+1 with wrap-around.
module or_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  grant,
    output logic            found
);
    // Unrolled per pointer value so every req index is a constant, which keeps
    // non-power-of-two NREQ from ever indexing past the vector.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int l = 0; l < NREQ; l++) begin
            if (last == IDW'(l)) begin
                for (int i = 1; i <= NREQ; i++) begin
                    if (!found && req[(l + i) % NREQ]) begin
                        grant = IDW'((l + i) % NREQ);
                        found = 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/or_4_bit_arbiter.sv
// Round-robin arbiter/sequencer sharing one or_4_bit gate among NREQ requesters.
// Define OR_ARB_SELFCHECK_EN to build the sticky result self-check on err.
module or_4_bit_arbiter
    import or_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int SETTLE = 1,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    or_4_bit_arbiter_if.slave bus,
    output logic              or_a,
    output logic              or_b,
    output logic              or_c,
    output logic              or_d,
    input  logic              or_s,
    output logic              busy,
    output logic              err
);
    state_t          state, state_d;
    logic [IDW-1:0]  last, last_d;
    logic [IDW-1:0]  gid, gid_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [IDW-1:0]  pick;
    logic            found;
    logic [CNTW-1:0] cnt, cnt_d;
    logic [OPW-1:0]  drv, drv_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            res_valid_q, res_valid_d;
    logic            res_q, res_d;
    logic            settle_done;

    or_arb_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (bus.req),
        .last  (last),
        .grant (pick),
        .found (found)
    );

    assign settle_done = (state == DRIVE) && (cnt == '0);

    // NOTE: every next-value signal is given its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state;
        last_d      = last;
        gid_d       = gid;
        cnt_d       = cnt;
        drv_d       = drv;
        ack_d       = '0;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_d       = res_q;
        case (state)
            IDLE: begin
                if (found) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (pick == IDW'(k)) drv_d = bus.op[OPW*k +: OPW];
                    end
                    gid_d   = pick;
                    cnt_d   = CNTW'(SETTLE - 1);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (!settle_done) begin
                    cnt_d = cnt - CNTW'(1);
                end else begin
                    // Pointer advances past the winner, so its stale req is skipped.
                    res_d    = or_s;
                    res_id_d = gid;
                    for (int k = 0; k < NREQ; k++) begin
                        ack_d[k] = (gid == IDW'(k));
                    end
                    res_valid_d = 1'b1;
                    last_d      = gid;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // captures the pre-edge values produced by the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= IDW'(NREQ - 1);
            gid         <= '0;
            cnt         <= '0;
            drv         <= '0;
            ack_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_q       <= 1'b0;
        end else begin
            state       <= state_d;
            last        <= last_d;
            gid         <= gid_d;
            cnt         <= cnt_d;
            drv         <= drv_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_q       <= res_d;
        end
    end

    assign {or_d, or_c, or_b, or_a} = drv;
    assign bus.ack       = ack_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res       = res_q;
    assign busy          = (state == DRIVE) || (state == DONE);

`ifdef OR_ARB_SELFCHECK_EN
    logic err_q;

    // Gate output is judged at the same instant it is captured into res.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (settle_done && (or_s != or_reduce(drv))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_or_4_bit_arbiter.sv
// Scoreboard bench for or_4_bit_arbiter: SETTLE=1 instance for ordering/results,
// SETTLE=3 instance for latency and mid-transaction reset.
module tb_or_4_bit_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int SETTLE  = 1;
    localparam int SETTLE3 = 3;
    localparam int LIMIT   = 300;

    typedef struct {
        int id;
        int res;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_m = NREQ - 1;
    int   rr_left[NREQ];
    int   timer[NREQ];

    logic clk = 1'b0;
    logic rst_n;
    logic force_zero = 1'b0;

    always #5 clk = ~clk;

    or_4_bit_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    or_4_bit_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus3 ();

    logic or_a, or_b, or_c, or_d, or_s, busy, err;
    logic a3, b3, c3, d3, s3, busy3, err3;

    assign or_s = force_zero ? 1'b0 : (or_a | or_b | or_c | or_d);
    assign s3   = a3 | b3 | c3 | d3;

    or_4_bit_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .or_a(or_a), .or_b(or_b), .or_c(or_c), .or_d(or_d), .or_s(or_s),
        .busy(busy), .err(err)
    );

    or_4_bit_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE3), .IDW(IDW)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3),
        .or_a(a3), .or_b(b3), .or_c(c3), .or_d(d3), .or_s(s3),
        .busy(busy3), .err(err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rule: first pending requester above the last winner, wrapping.
    function automatic int rr_next(input logic [NREQ-1:0] pend, input int from);
        for (int i = 1; i <= NREQ; i++) begin
            if (pend[(from + i) % NREQ]) return (from + i) % NREQ;
        end
        return -1;
    endfunction

    // Predict the completions of one batch of simultaneously pending requests.
    task automatic predict(input logic [NREQ-1:0] mask, input logic [4*NREQ-1:0] ops);
        logic [NREQ-1:0] pend = mask;
        while (pend != '0) begin
            int   g;
            exp_t e;
            g     = rr_next(pend, last_m);
            e.id  = g;
            e.res = force_zero ? 0 : int'(|ops[4*g +: 4]);
            exp_q.push_back(e);
            pend[g] = 1'b0;
            last_m  = g;
        end
    endtask

    task automatic issue(input logic [NREQ-1:0] mask, input logic [4*NREQ-1:0] ops);
        bus.op  = ops;
        bus.req = bus.req | mask;
        predict(mask, ops);
    endtask

    // One clock of requester behaviour: drop on ack, optional re-raise 2 cycles later.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < NREQ; k++) begin
            if (bus.ack[k]) begin
                bus.req[k] = 1'b0;
                if (rr_left[k] > 0) begin
                    rr_left[k]--;
                    timer[k] = 2;
                end
            end else if (timer[k] > 0) begin
                timer[k]--;
                if (timer[k] == 0) bus.req[k] = 1'b1;
            end
        end
    endtask

    function automatic bit timers_idle();
        for (int k = 0; k < NREQ; k++) if (timer[k] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done(input string name);
        int n = 0;
        while ((bus.req != '0 || busy || !timers_idle()) && n < LIMIT) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 32'(n >= LIMIT), 0);
        check({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.res_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", bus.res_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_id", bus.res_id, e.id);
                    check("res", bus.res, e.res);
                    check("ack_onehot", bus.ack, 32'(1) << e.id);
                    check("busy_with_ack", busy, 1);
                end
            end else if (rst_n === 1'b1 && bus.ack !== '0) begin
                check("stray_ack", bus.ack, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*NREQ-1:0] ops;
        logic [NREQ-1:0]   mask;
        logic [NREQ-1:0]   acc_ack;
        logic              acc_busy;
        int                n;

        for (int k = 0; k < NREQ; k++) begin
            rr_left[k] = 0;
            timer[k]   = 0;
        end
        bus.req  = '0;
        bus.op   = '0;
        bus3.req = '0;
        bus3.op  = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;

        // Reset with every requester asking; each re-raises once after its ack.
        ops     = 16'h8421;
        bus.op  = ops;
        bus.req = 4'b1111;
        for (int k = 0; k < NREQ; k++) rr_left[k] = 1;
        predict(4'b1111, ops);
        predict(4'b1111, ops);
        tick();
        tick();
        check("rst_ack", bus.ack, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_or", {or_d, or_c, or_b, or_a}, 0);
        check("rst_busy", busy, 0);
        check("rst_res_id", bus.res_id, 0);
        check("rst_res", bus.res, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        wait_done("fair");

        // Single request: gate driven with b only, result 1 from requester 2.
        issue(4'b0100, 16'h0200);
        tick();
        check("single_drive", {or_d, or_c, or_b, or_a}, 4'b0010);
        check("single_busy", busy, 1);
        wait_done("single");

        issue(4'b0010, 16'h0000);
        wait_done("zero_op");

        // req dropped and op changed mid-DRIVE: captured operand still wins.
        issue(4'b1000, 16'h8000);
        tick();
        bus.req[3] = 1'b0;
        bus.op     = '0;
        wait_done("early_drop");

        for (int r = 0; r < 25; r++) begin
            mask = NREQ'($urandom_range(1, 15));
            for (int k = 0; k < NREQ; k++) begin
                ops[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            end
            issue(mask, ops);
            wait_done("random");
            repeat ($urandom_range(0, 2)) tick();
        end

`ifdef OR_ARB_SELFCHECK_EN
        check("err_clean", err, 0);
        force_zero = 1'b1;
        issue(4'b0001, 16'h0008);
        wait_done("sc_forced");
        force_zero = 1'b0;
        check("err_set", err, 1);
        issue(4'b0110, 16'h0310);
        wait_done("sc_after");
        check("err_sticky", err, 1);
`else
        check("err_tied", err, 0);
`endif

        // SETTLE=3 instance: reset while in DRIVE aborts the transaction.
        bus3.op  = 16'h0500;
        bus3.req = 4'b0100;
        tick();
        check("d3_busy", busy3, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("d3_rst_busy", busy3, 0);
        check("d3_rst_ack", bus3.ack, 0);
        check("d3_rst_or", {d3, c3, b3, a3}, 0);
        bus3.req = '0;
        last_m   = NREQ - 1;
        tick();
        tick();
        rst_n    = 1'b1;
        acc_ack  = '0;
        acc_busy = 1'b0;
        repeat (6) begin
            tick();
            acc_ack  = acc_ack | bus3.ack;
            acc_busy = acc_busy | busy3;
        end
        check("d3_no_ack", acc_ack, 0);
        check("d3_idle", acc_busy, 0);
`ifdef OR_ARB_SELFCHECK_EN
        check("err_cleared", err, 0);
`endif

        // Retry: ack visible exactly SETTLE+1 cycles after req is driven.
        bus3.req = 4'b0100;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus3.ack == '0 && n < 20);
        check("d3_latency", n, SETTLE3 + 1);
        check("d3_ack", bus3.ack, 4'b0100);
        check("d3_res_id", bus3.res_id, 2);
        check("d3_res", bus3.res, 1);
        bus3.req = '0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
